// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with a persistent carry flag for ADC/SBC chains
// and a shift-add multiplier that retires one multiplier bit per cycle.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             c_flag
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [SHW:0] SH_LIMIT = WIDTH[SHW:0];

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_ADC  = 4'hB;
    localparam logic [3:0] OP_SBC  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     y_reg;
    logic                 carry_reg, overflow_reg, valid_reg, c_flag_reg;
    logic [2*WIDTH-1:0]   acc_reg, mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CW-1:0]        count_reg;

    logic                 accept, mul_start, mul_done;
    logic [SHW-1:0]       sh;
    logic                 sh_big;
    logic                 add_cin, sub_cin;
    logic [WIDTH:0]       add_sum, sub_sum;
    logic [WIDTH-1:0]     sra_res;
    logic [WIDTH-1:0]     alu_y;
    logic                 alu_c, alu_v, alu_cupd;
    logic [2*WIDTH-1:0]   partial, step_sum;

    assign in_ready  = (state_reg == S_IDLE) && (!valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign mul_done  = (state_reg == S_MUL) && (count_reg == CW'(1));

    // Shift amounts past the word only exist when WIDTH is not a power of two.
    assign sh      = b[SHW-1:0];
    assign sh_big  = {1'b0, sh} >= SH_LIMIT;
    assign sra_res = $unsigned($signed(a) >>> sh);

    assign add_cin = (op == OP_ADC) ? c_flag_reg : 1'b0;
    assign sub_cin = (op == OP_SBC) ? c_flag_reg : 1'b1;
    assign add_sum = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, add_cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, sub_cin};

    always_comb begin
        alu_y    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_cupd = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_y    = add_sum[WIDTH-1:0];
                alu_c    = add_sum[WIDTH];
                alu_v    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
                alu_cupd = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                alu_y    = sub_sum[WIDTH-1:0];
                alu_c    = sub_sum[WIDTH];
                alu_v    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
                alu_cupd = 1'b1;
            end
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_NOR:  alu_y = ~(a | b);
            OP_SLL:  alu_y = sh_big ? '0 : (a << sh);
            OP_SRL:  alu_y = sh_big ? '0 : (a >> sh);
            OP_SRA:  alu_y = sh_big ? {WIDTH{a[WIDTH-1]}} : sra_res;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: ;
        endcase
    end

    assign partial  = mplier_reg[0] ? mcand_reg : '0;
    assign step_sum = acc_reg + partial;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (mul_start)
                    state_next = S_MUL;
                else if (!accept && valid_reg && !out_ready)
                    state_next = S_HOLD;
            end
            S_MUL:   if (mul_done) state_next = S_IDLE;
            S_HOLD:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg        <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
            c_flag_reg   <= 1'b0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            count_reg    <= '0;
        end else if (mul_start) begin
            // Any previous result is consumed by this same handshake.
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            count_reg  <= CW'(WIDTH);
            valid_reg  <= 1'b0;
        end else if (accept) begin
            y_reg        <= alu_y;
            carry_reg    <= alu_c;
            overflow_reg <= alu_v;
            valid_reg    <= 1'b1;
            if (alu_cupd)
                c_flag_reg <= alu_c;
        end else if (state_reg == S_MUL) begin
            acc_reg    <= step_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
            if (mul_done) begin
                y_reg        <= step_sum[WIDTH-1:0];
                carry_reg    <= |step_sum[2*WIDTH-1:WIDTH];
                overflow_reg <= 1'b0;
                valid_reg    <= 1'b1;
            end
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign y         = y_reg;
    assign carry_out = carry_reg;
    assign overflow  = overflow_reg;
    assign zero      = (y_reg == '0);
    assign negative  = y_reg[WIDTH-1];
    assign c_flag    = c_flag_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an arithmetic reference model checked every cycle on an
// 8-bit instance, plus directed wide-word shift/compare cases on 16/12-bit instances.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [3:0] op8 = 4'h0;
    logic [7:0] a8 = 8'h0, b8 = 8'h0;
    logic       in_ready8, out_valid8, co8, ov8, z8, n8, cf8;
    logic [7:0] y8;

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .carry_out(co8), .overflow(ov8), .zero(z8), .negative(n8), .c_flag(cf8));

    // wide instances share handshake and opcode
    logic        in_valid_w = 1'b0, out_ready_w = 1'b1;
    logic [3:0]  op_w = 4'h0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [11:0] a12 = '0, b12 = '0;
    logic        in_ready16, out_valid16, co16, ov16, z16, n16, cf16_dut;
    logic        in_ready12, out_valid12, co12, ov12, z12, n12, cf12_dut;
    logic [15:0] y16;
    logic [11:0] y12;

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op_w), .out_valid(out_valid16), .out_ready(out_ready_w),
        .y(y16), .carry_out(co16), .overflow(ov16), .zero(z16), .negative(n16), .c_flag(cf16_dut));

    alu_pipe #(.WIDTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready12),
        .a(a12), .b(b12), .op(op_w), .out_valid(out_valid12), .out_ready(out_ready_w),
        .y(y12), .carry_out(co12), .overflow(ov12), .zero(z12), .negative(n12), .c_flag(cf12_dut));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        cupd;
        logic        v;
        logic        c;
        logic [31:0] y;
    } res_t;

    // Reference: plain integer arithmetic on w-bit words.
    function automatic res_t ref_alu(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                     input logic cf, input int w);
        res_t   r;
        longint one, m, ua, ub, sa, sb, s, sv, hi, lo, cin;
        int     shw, sh;
        one = 1;
        m   = (one << w) - 1;
        ua  = longint'(xa) & m;
        ub  = longint'(xb) & m;
        sa  = (((ua >> (w-1)) & 1) != 0) ? ua - (one << w) : ua;
        sb  = (((ub >> (w-1)) & 1) != 0) ? ub - (one << w) : ub;
        hi  = (one << (w-1)) - 1;
        lo  = -(one << (w-1));
        shw = 0;
        while ((1 << shw) < w) shw++;
        sh  = int'(ub & ((one << shw) - 1));
        r   = '0;
        case (o)
            4'h0, 4'hB: begin
                cin    = (o == 4'hB && cf) ? 1 : 0;
                s      = ua + ub + cin;
                r.y    = 32'(s & m);
                r.c    = ((s >> w) & 1) != 0;
                sv     = sa + sb + cin;
                r.v    = (sv > hi) || (sv < lo);
                r.cupd = 1'b1;
            end
            4'h1, 4'hC: begin
                cin    = (o == 4'hC && !cf) ? 1 : 0;   // borrow in
                s      = ua - ub - cin;
                r.y    = 32'(s & m);
                r.c    = (s >= 0);
                sv     = sa - sb - cin;
                r.v    = (sv > hi) || (sv < lo);
                r.cupd = 1'b1;
            end
            4'h2: r.y = 32'(ua & ub);
            4'h3: r.y = 32'(ua | ub);
            4'h4: r.y = 32'(ua ^ ub);
            4'h5: r.y = 32'(~(ua | ub) & m);
            4'h6: r.y = (sh >= w) ? 32'd0 : 32'((ua << sh) & m);
            4'h7: r.y = 32'(ua >> sh);
            4'hA: r.y = 32'((sa >>> sh) & m);
            4'h8: r.y = (sa < sb) ? 32'd1 : 32'd0;
            4'h9: r.y = (ua < ub) ? 32'd1 : 32'd0;
            4'hD: begin
                s   = ua * ub;
                r.y = 32'(s & m);
                r.c = (s >> w) != 0;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Cycle-level model of the 8-bit instance
    logic       m_valid = 1'b0, m_c = 1'b0, m_v = 1'b0, m_cf = 1'b0, m_hold = 1'b0;
    logic [7:0] m_y = 8'h0;
    int         m_busy = 0;
    res_t       m_pend;

    initial begin
        res_t r;
        logic rdy_pre, acc, idle_pre, valid_pre;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 0; m_y = 0; m_c = 0; m_v = 0; m_cf = 0; m_busy = 0; m_hold = 0;
            end else begin
                idle_pre  = (m_busy == 0) && !m_hold;
                valid_pre = m_valid;
                rdy_pre   = idle_pre && (!m_valid || out_ready8);
                acc       = in_valid8 && rdy_pre;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_y = m_pend.y[7:0]; m_c = m_pend.c; m_v = 1'b0; m_valid = 1'b1;
                    end
                end else if (acc) begin
                    r = ref_alu(op8, 32'(a8), 32'(b8), m_cf, 8);
                    if (op8 == 4'hD) begin
                        m_pend = r; m_busy = 8; m_valid = 1'b0;
                    end else begin
                        m_y = r.y[7:0]; m_c = r.c; m_v = r.v; m_valid = 1'b1;
                        if (r.cupd) m_cf = r.c;
                    end
                end else if (m_valid && out_ready8) begin
                    m_valid = 1'b0;
                end
                if (m_hold) begin
                    if (out_ready8) m_hold = 1'b0;
                end else if (idle_pre && !acc && valid_pre && !out_ready8) begin
                    m_hold = 1'b1;
                end
            end
            #1;
            chk("m_out_valid", 32'(out_valid8), 32'(m_valid));
            chk("m_in_ready", 32'(in_ready8),
                32'((m_busy == 0) && !m_hold && (!m_valid || out_ready8)));
            chk("m_y", 32'(y8), 32'(m_y));
            chk("m_c_flag", 32'(cf8), 32'(m_cf));
            if (m_valid) begin
                chk("m_carry_out", 32'(co8), 32'(m_c));
                chk("m_overflow", 32'(ov8), 32'(m_v));
                chk("m_zero", 32'(z8), 32'(m_y == 8'h0));
                chk("m_negative", 32'(n8), 32'(m_y[7]));
            end
        end
    end

    task automatic send8(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb, output time t);
        bit done = 0;
        t = 0;
        @(negedge clk);
        in_valid8 = 1'b1; op8 = o; a8 = xa; b8 = xb;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (in_ready8) begin
                @(posedge clk);
                t = $time / 10;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("send8_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic drop8();
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid8(input int limit, output time t);
        bit ok = 0;
        t = 0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(posedge clk);
            t = $time / 10;
            #1;
            if (out_valid8) ok = 1;
        end
        if (!ok) chk("wait_valid8_timeout", 32'd1, 32'd0);
    endtask

    logic cf16 = 1'b0, cf12 = 1'b0;

    task automatic wide(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb);
        res_t r;
        @(negedge clk);
        in_valid_w = 1'b1; op_w = o; a16 = xa; b16 = xb; a12 = xa[11:0]; b12 = xb[11:0];
        #1;
        chk("w16_in_ready", 32'(in_ready16), 32'd1);
        chk("w12_in_ready", 32'(in_ready12), 32'd1);
        @(posedge clk);
        #1;
        r = ref_alu(o, 32'(xa), 32'(xb), cf16, 16);
        if (r.cupd) cf16 = r.c;
        chk("w16_y", 32'(y16), r.y);
        chk("w16_carry", 32'(co16), 32'(r.c));
        chk("w16_ovf", 32'(ov16), 32'(r.v));
        chk("w16_c_flag", 32'(cf16_dut), 32'(cf16));
        r = ref_alu(o, 32'(xa[11:0]), 32'(xb[11:0]), cf12, 12);
        if (r.cupd) cf12 = r.c;
        chk("w12_y", 32'(y12), r.y);
        chk("w12_carry", 32'(co12), 32'(r.c));
        chk("w12_ovf", 32'(ov12), 32'(r.v));
        chk("w12_c_flag", 32'(cf12_dut), 32'(cf12));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0, t1;
        logic [3:0] ro;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_y", 32'(y8), 32'd0);
        chk("rst_zero", 32'(z8), 32'd1);
        chk("rst_negative", 32'(n8), 32'd0);
        chk("rst_c_flag", 32'(cf8), 32'd0);
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // signed overflow into the sign bit
        send8(4'h0, 8'h7F, 8'h01, t0);
        $display("ADD 7f+01: y=%0h v=%0b c=%0b", y8, ov8, co8);
        chk("add_y", 32'(y8), 32'h80);
        chk("add_ovf", 32'(ov8), 32'd1);
        chk("add_carry", 32'(co8), 32'd0);
        chk("add_neg", 32'(n8), 32'd1);
        chk("add_zero", 32'(z8), 32'd0);

        // carry chain ADD then ADC back-to-back
        send8(4'h0, 8'hFF, 8'h01, t0);
        $display("ADD ff+01: y=%0h c=%0b cf=%0b", y8, co8, cf8);
        chk("chain_add_y", 32'(y8), 32'h00);
        chk("chain_add_carry", 32'(co8), 32'd1);
        chk("chain_add_zero", 32'(z8), 32'd1);
        chk("chain_add_cflag", 32'(cf8), 32'd1);
        send8(4'hB, 8'h00, 8'h00, t1);
        $display("ADC 00+00: y=%0h cf=%0b", y8, cf8);
        chk("chain_adc_y", 32'(y8), 32'h01);
        chk("chain_adc_cflag", 32'(cf8), 32'd0);
        chk("chain_b2b_cycles", 32'(t1 - t0), 32'd1);
        drop8();

        // multi-cycle multiply
        send8(4'hD, 8'h10, 8'h11, t0);
        drop8();
        wait_valid8(40, t1);
        $display("MUL 10*11: y=%0h c=%0b latency=%0d", y8, co8, t1 - t0);
        chk("mul_latency", 32'(t1 - t0), 32'd8);
        chk("mul1_y", 32'(y8), 32'h10);
        chk("mul1_carry", 32'(co8), 32'd1);
        send8(4'hD, 8'h03, 8'h05, t0);
        drop8();
        wait_valid8(40, t1);
        $display("MUL 03*05: y=%0h c=%0b", y8, co8);
        chk("mul2_y", 32'(y8), 32'h0F);
        chk("mul2_carry", 32'(co8), 32'd0);

        // backpressure holds the SUB result; queued XOR waits
        send8(4'h1, 8'h00, 8'h01, t0);
        chk("sub_y", 32'(y8), 32'hFF);
        chk("sub_carry", 32'(co8), 32'd0);
        @(negedge clk);
        out_ready8 = 1'b0; op8 = 4'h4; a8 = 8'h0F; b8 = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            $display("HOLD cycle %0d: y=%0h in_ready=%0b", k, y8, in_ready8);
            chk("hold_y", 32'(y8), 32'hFF);
            chk("hold_carry", 32'(co8), 32'd0);
            chk("hold_in_ready", 32'(in_ready8), 32'd0);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        begin
            bit seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(posedge clk);
                #1;
                if (out_valid8 && y8 == 8'h33) seen = 1;
            end
            $display("XOR after release: seen=%0b", seen);
            chk("hold_release_xor", 32'(seen), 32'd1);
        end
        drop8();

        // reset in the middle of a multiply
        send8(4'h0, 8'hFF, 8'h01, t0);
        drop8();
        send8(4'hD, 8'h07, 8'h09, t0);
        drop8();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("RESET mid-MUL: v=%0b y=%0h cf=%0b", out_valid8, y8, cf8);
        chk("midrst_valid", 32'(out_valid8), 32'd0);
        chk("midrst_y", 32'(y8), 32'd0);
        chk("midrst_cflag", 32'(cf8), 32'd0);
        chk("midrst_in_ready", 32'(in_ready8), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send8(4'h0, 8'h12, 8'h34, t0);
        $display("ADD after reset: y=%0h", y8);
        chk("post_rst_add", 32'(y8), 32'h46);
        chk("post_rst_valid", 32'(out_valid8), 32'd1);
        drop8();

        // wide instances: shifts, compares, out-of-range shift amounts
        wide(4'hA, 16'h8000, 16'h0004);
        $display("W16 SRA 8000>>>4: y=%0h", y16);
        chk("w16_sra_lit", 32'(y16), 32'hF800);
        wide(4'h9, 16'h0001, 16'hFFFF);
        $display("W16 SLTU 0001<ffff: y=%0h", y16);
        chk("w16_sltu_lit", 32'(y16), 32'd1);
        wide(4'h8, 16'h0001, 16'hFFFF);
        $display("W16 SLT 0001<ffff: y=%0h", y16);
        chk("w16_slt_lit", 32'(y16), 32'd0);
        wide(4'h6, 16'h0FFF, 16'h000D);
        chk("w12_sll_big_lit", 32'(y12), 32'd0);
        wide(4'hA, 16'h0800, 16'h000C);
        chk("w12_sra_big_lit", 32'(y12), 32'hFFF);
        wide(4'h7, 16'h0FFF, 16'h000F);
        chk("w12_srl_big_lit", 32'(y12), 32'd0);
        wide(4'h7, 16'h0FFF, 16'h000B);
        chk("w12_srl_lit", 32'(y12), 32'd1);
        for (int k = 0; k < 60; k++) begin
            ro = 4'($urandom % 15);
            if (ro == 4'hD) ro = 4'hF;
            wide(ro, 16'($urandom), 16'($urandom));
        end
        @(negedge clk);
        in_valid_w = 1'b0;

        // randomized traffic on the 8-bit instance, checked by the model
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            in_valid8  = ($urandom % 10) < 7;
            op8        = 4'($urandom);
            a8         = ($urandom % 4 == 0) ? 8'h7F : 8'($urandom);
            b8         = ($urandom % 4 == 0) ? 8'h80 : 8'($urandom);
            out_ready8 = ($urandom % 4) != 0;
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Operand width is set by WIDTH; operands enter through a valid/ready input port.
- Results and flags are registered and leave through a valid/ready output port.
- Adds a persistent carry flag for multi-word ADC/SBC chains, extra ops (SLTU, SRA), and a multi-cycle shift-add multiply.
- Sits between the datapath sequencer and the register-file writeback.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount field width. Derived; must not be overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount.
- op  in  4  operation code.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  WIDTH  registered result.
- carry_out  out  1  registered unsigned carry, or multiply high-part-nonzero.
- overflow  out  1  registered signed overflow.
- zero  out  1  (y == 0), derived from registered y.
- negative  out  1  y[WIDTH-1].
- c_flag  out  1  persistent carry flag used by ADC/SBC.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, y=0, carry_out=0, overflow=0, c_flag=0.
  - FSM=IDLE, multiply accumulator and counter cleared.
  - zero therefore resets to 1, negative to 0.
- FSM states: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready), i.e. combinational pass-through of out_ready when a result is being drained.
- Accept: in_valid && in_ready at a rising edge. Inputs are ignored otherwise.
- Single-cycle ops accepted at edge N:
  - y and flags load at edge N, out_valid=1 after edge N.
  - Back-to-back throughput: 1 op/cycle while out_ready=1.
- Opcodes (the flags not listed for an op load 0):
  - 0 ADD: {carry_out,y} = a+b; V = (a.msb==b.msb) && (y.msb!=a.msb).
  - 1 SUB: y = a+~b+1; carry_out = carry (1 = no borrow); V = (a.msb!=b.msb) && (y.msb!=a.msb).
  - 2 AND, 3 OR, 4 XOR, 5 NOR: bitwise.
  - 6 SLL, 7 SRL, A SRA: shift by sh=b[SHW-1:0]. If sh>=WIDTH (non-power-of-2 WIDTH only), SLL/SRL give 0 and SRA gives all sign bits.
  - 8 SLT: signed compare, y = 1 or 0.
  - 9 SLTU: unsigned compare, y = 1 or 0.
  - B ADC: a+b+c_flag; carry/V rules as ADD.
  - C SBC: a+~b+c_flag; carry/V rules as SUB.
  - D MUL: unsigned multi-cycle multiply, described below.
  - E, F: y=0, all flags 0, c_flag unchanged; still produce a result (out_valid=1).
- c_flag:
  - Loaded with carry_out when an ADD/SUB/ADC/SBC result is registered.
  - Unchanged by every other op.
  - Because in_ready requires the output stage to drain, ADC issued right after ADD sees the updated c_flag.
- MUL:
  - Accepted at edge N: IDLE->MUL; latch a, b; counter = WIDTH.
  - Shift-add one bit per cycle.
  - At edge N+WIDTH: y = low WIDTH bits of the product; carry_out = |high WIDTH bits; overflow=0; out_valid=1; state->IDLE.
  - in_ready=0 throughout MUL.
- HOLD:
  - Entered from IDLE when out_valid && !out_ready.
  - y and all flags stay stable until out_ready.
  - out_valid && out_ready with no new accept: out_valid->0 next edge, y retains its value.
- Simultaneous out_ready and new accept: the new result overwrites in the same edge and out_valid stays 1.
- rst_n low at any time (including mid-MUL or HOLD): immediate return to reset values; the partial product is discarded.

Test Plan:
- WIDTH=8, ADD a=8'h7F b=8'h01 -> next cycle y=8'h80, overflow=1, carry_out=0, negative=1, zero=0.
- WIDTH=8, ADD 8'hFF+8'h01, then back-to-back ADC 8'h00+8'h00 -> first y=8'h00, carry_out=1, zero=1, c_flag=1; second y=8'h01, c_flag=0; one result per cycle.
- WIDTH=8, MUL a=8'h10 b=8'h11 -> in_ready=0 for 8 cycles; out_valid rises 8 edges after accept with y=8'h10, carry_out=1; a second MUL 8'h03*8'h05 gives y=8'h0F, carry_out=0.
- Backpressure: out_ready=0 for 5 cycles after a SUB 8'h00-8'h01 -> y=8'hFF, carry_out=0 held stable; in_ready=0; new in_valid ignored until out_ready=1.
- WIDTH=16, SRA a=16'h8000 sh=4 -> y=16'hF800; SLTU 16'h0001 vs 16'hFFFF -> y=1; SLT on the same operands -> y=0.
- Assert rst_n low 3 cycles into a MUL -> out_valid=0, y=0, c_flag=0, state IDLE; the next ADD completes normally.
